gray_code_pipe: RTL and testbench
=================================

// Module: gray_code_pipe
// PURPOSE
//  Pipelined, parametrised Gray/binary converter with valid/ready handshake and per-beat direction.
//  Adds a Gray-step checker that flags beats whose Gray value differs from the previous beat's in != 1 bit.
//  Sits between a Gray-coded source (encoder, CDC pointer) and binary consumers, or the reverse.
//  Fully elastic: absorbs downstream backpressure without loss.
// PARAMETERS
//  N         4   data width in bits (>= 2)
//  STAGES    2   pipeline depth = latency in cycles (1..N-1)
//  CHECK_EN  1   1: Gray-step checker active; 0: out_step_err tied 0
// PORTS
//  clk           in   1  single clock; all state updates on rising edge
//  rst           in   1  synchronous, active-high reset
//  in_valid      in   1  input beat present
//  in_ready      out  1  block can accept the beat this cycle
//  in_data       in   N  value to convert
//  in_mode       in   1  0: Gray->binary; 1: binary->Gray (MODE_G2B/MODE_B2G)
//  out_valid     out  1  output beat present
//  out_ready     in   1  consumer accepts the beat this cycle
//  out_data      out  N  converted value
//  out_mode      out  1  in_mode of the beat, carried through
//  out_step_err  out  1  Gray-step violation flag for this beat
// BEHAVIOUR
//  - Transfer: a beat moves on a port when valid && ready in the same cycle.
//  - Valid, once high, holds with data/mode/err stable until accepted; ready never depends on
//    in_valid (no comb path in_valid->in_ready).
//  - Reset: every stage valid = 0, out_valid = 0, out_data = 0, out_mode = 0, out_step_err = 0,
//    checker history cleared. in_ready = 1 in the first cycle after rst deasserts.
//  - Reset mid-operation: in-flight beats are discarded, with no output for them afterwards.
//    in_ready is don't-care while rst is high.
//  - Each stage holds a valid bit plus payload. A stage loads when it is empty or its contents
//    leave this cycle.
//  - in_ready = !v[0] || advance[0], with a combinational ready chain from out_ready.
//    Full throughput of 1 beat/clk under continuous out_ready.
//  - Latency: a beat accepted in cycle t is presented on out_* in cycle t+STAGES when unstalled.
//  - Conversion, MSB first:
//      G2B: b[N-1] = g[N-1]; b[i] = b[i+1] ^ g[i].
//      B2G: g[i] = b[i] ^ b[i+1]; g[N-1] = b[N-1].
//  - G2B prefix chain is split across stages: stage k resolves bits
//    [N-1-k*C .. N-C*(k+1)], where C = ceil((N-1)/STAGES). Partial result and raw input are carried
//    forward. B2G is finished in stage 0; later stages are pure delay.
//  - Checker: the beat's Gray value is in_data (G2B) or the computed Gray (B2G).
//    err = popcount(gray ^ prev_gray) != 1, evaluated against the previous ACCEPTED beat of either mode.
//    First beat after reset: err = 0. prev_gray updates only on input transfer.
//    The flag travels with the beat and is aligned to out_data.
//  - Mode may change beat to beat; no bubble is inserted.
//  - Pipeline full and out_ready = 0: in_ready = 0, contents frozen.
//    out_ready rising with in_valid high: accept and emit in the same cycle.
// STRUCTURE
//  - gray_pkg: MODE_G2B = 1'b0, MODE_B2G = 1'b1, and function popcount_is_one(vec) sized by N.
//  - Sub-module gray_conv_stage #(N, LO, HI):
//      - one pipeline register stage resolving bits HI..LO;
//      - inputs: valid/ready, raw, partial, mode, err; outputs: the same.
//    The top instantiates STAGES copies via generate, plus the checker in the input stage.
// TESTING (N=4, STAGES=2 unless stated)
//  1. G2B 4'b0110, out_ready=1 -> out_data=4'b0100, out_mode=0, two cycles after accept.
//  2. B2G 4'b1011 -> out_data=4'b1110. Exhaustive: all 16 values B2G then fed back G2B must equal
//     the originals; 1 beat/clk sustained.
//  3. Gray stream 0000,0001,0011,0010,0111,0111 -> out_step_err = 0,0,0,0,1,1
//     (2-bit step, then 0-bit repeat).
//  4. Hold out_ready=0 while offering 4 beats:
//       - accept exactly 2, then in_ready=0 and out_data stable;
//       - release out_ready -> all 4 beats appear in order, none duplicated.
//  5. Assert rst for 1 cycle with 2 beats in flight:
//       - out_valid=0 next cycle, none of those beats emerge;
//       - next beat's step_err=0 regardless of value.
//  6. Sweep N=8, STAGES in {1,3,7} with random valid/ready toggling:
//       - scoreboard matches a reference model;
//       - latency = STAGES whenever unstalled.

Source files
------------

// File: rtl/gray_pkg.sv
// gray_pkg: shared definitions for the Gray/binary conversion pipeline.
//   mode_e            - per-beat conversion direction
//   GRAY_MAX_W        - widest data path the helpers below accept
//   popcount_is_one() - true when exactly one bit of vec is set
package gray_pkg;

  typedef enum logic {
    MODE_G2B = 1'b0,
    MODE_B2G = 1'b1
  } mode_e;

  localparam int unsigned GRAY_MAX_W = 64;

  // Callers zero-extend their N-bit vector to GRAY_MAX_W; extra zeros do not
  // change the answer. A single set bit is the only non-zero value v with
  // v & (v-1) == 0.
  function automatic logic popcount_is_one(input logic [GRAY_MAX_W-1:0] vec);
    return (vec != '0) && ((vec & (vec - GRAY_MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/gray_conv_stage.sv
// gray_conv_stage: one elastic register stage of the Gray/binary pipeline.
//   Resolves Gray->binary bits HI..LO (MSB first) and registers the beat.
//   A stage whose HI is N-1 also finishes binary->Gray; otherwise B2G beats
//   pass through unchanged. Empty ranges (HI < LO) make the stage a pure delay.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   i_valid / o_ready  upstream handshake
//   i_raw, i_part      original input value, partially resolved result
//   i_mode, i_err      direction and step-error flag travelling with the beat
//   o_valid / i_ready  downstream handshake
//   o_raw, o_part, o_mode, o_err  registered beat
module gray_conv_stage
  import gray_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int          LO = 0,
  parameter int          HI = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_raw,
  input  logic [N-1:0] i_part,
  input  logic         i_mode,
  input  logic         i_err,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_raw,
  output logic [N-1:0] o_part,
  output logic         o_mode,
  output logic         o_err
);

  logic         r_valid;
  logic [N-1:0] r_raw;
  logic [N-1:0] r_part;
  logic         r_mode;
  logic         r_err;
  // One spare zero bit above the MSB lets the top bit use the same
  // b[i] = b[i+1] ^ g[i] rule as every other bit.
  logic [N:0]   w_ext;

  always_comb begin
    w_ext = {1'b0, i_part};
    if (i_mode == MODE_B2G) begin
      if (HI == int'(N) - 1) w_ext[N-1:0] = i_raw ^ (i_raw >> 1);
    end else begin
      for (int unsigned j = 0; j < N; j++) begin
        if ((int'(N - 1 - j) <= HI) && (int'(N - 1 - j) >= LO))
          w_ext[N-1-j] = w_ext[N-j] ^ i_raw[N-1-j];
      end
    end
  end

  assign o_ready = !r_valid || i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_raw   <= '0;
      r_part  <= '0;
      r_mode  <= 1'b0;
      r_err   <= 1'b0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_raw  <= i_raw;
        r_part <= w_ext[N-1:0];
        r_mode <= i_mode;
        r_err  <= i_err;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_raw   = r_raw;
  assign o_part  = r_part;
  assign o_mode  = r_mode;
  assign o_err   = r_err;

endmodule

// File: rtl/gray_code_pipe.sv
// gray_code_pipe: elastic pipelined Gray<->binary converter with a Gray-step
// checker. Latency STAGES cycles, 1 beat/clk throughput.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready              input handshake
//   in_data, in_mode               value and direction (0 G2B, 1 B2G)
//   out_valid/out_ready            output handshake
//   out_data, out_mode             converted value and carried direction
//   out_step_err                   beat's Gray value differed from the previous
//                                  accepted beat's in other than exactly 1 bit
module gray_code_pipe
  import gray_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned STAGES   = 2,
  parameter int unsigned CHECK_EN = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_mode,
  output logic         out_step_err
);

  // Bits resolved per stage for the G2B prefix chain.
  localparam int unsigned C = (N - 1 + STAGES - 1) / STAGES;

  logic         w_valid [STAGES+1];
  logic         w_ready [STAGES+1];
  logic [N-1:0] w_raw   [STAGES+1];
  logic [N-1:0] w_part  [STAGES+1];
  logic         w_mode  [STAGES+1];
  logic         w_err   [STAGES+1];

  logic [N-1:0] w_gray;
  logic [N-1:0] r_prev_gray;
  logic         r_have_prev;
  logic         w_chk_err;
  logic [N-1:0] w_unused_raw;

  // Checker: compares against the previous accepted beat of either mode.
  assign w_gray    = (in_mode == MODE_B2G) ? (in_data ^ (in_data >> 1)) : in_data;
  assign w_chk_err = (CHECK_EN != 0) && r_have_prev &&
                     !popcount_is_one(GRAY_MAX_W'(w_gray ^ r_prev_gray));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_gray <= '0;
      r_have_prev <= 1'b0;
    end else if (in_valid && w_ready[0]) begin
      r_prev_gray <= w_gray;
      r_have_prev <= 1'b1;
    end
  end

  assign w_valid[0]      = in_valid;
  assign in_ready        = w_ready[0];
  assign w_raw[0]        = in_data;
  assign w_part[0]       = '0;
  assign w_mode[0]       = in_mode;
  assign w_err[0]        = w_chk_err;
  assign w_ready[STAGES] = out_ready;

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    // Last stage always reaches bit 0 so the chain completes even when
    // STAGES*C < N.
    localparam int HI_K = int'(N) - 1 - k * int'(C);
    localparam int LO_K = (k == int'(STAGES) - 1) ? 0 : int'(N) - int'(C) * (k + 1);

    gray_conv_stage #(.N(N), .LO(LO_K), .HI(HI_K)) u_stage (
      .clk    (clk),
      .rst    (rst),
      .i_valid(w_valid[k]),
      .o_ready(w_ready[k]),
      .i_raw  (w_raw[k]),
      .i_part (w_part[k]),
      .i_mode (w_mode[k]),
      .i_err  (w_err[k]),
      .o_valid(w_valid[k+1]),
      .i_ready(w_ready[k+1]),
      .o_raw  (w_raw[k+1]),
      .o_part (w_part[k+1]),
      .o_mode (w_mode[k+1]),
      .o_err  (w_err[k+1])
    );
  end

  assign w_unused_raw = w_raw[STAGES];

  assign out_valid    = w_valid[STAGES];
  assign out_data     = w_part[STAGES];
  assign out_mode     = w_mode[STAGES];
  assign out_step_err = w_err[STAGES];

endmodule

// File: tb/tb_gray_code_pipe.sv
// Bench for gray_code_pipe: directed N=4/STAGES=2 cases plus a randomized
// N=8 sweep over STAGES 1, 3 and 7 against a behavioural model.
module tb_gray_code_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: binary = XOR of all right shifts of the Gray value.
  function automatic logic [7:0] m_g2b(input logic [7:0] g);
    logic [7:0] b = '0;
    for (int s = 0; s < 8; s++) b ^= g >> s;
    return b;
  endfunction

  function automatic logic [7:0] m_b2g(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  // ---------------- N=4, STAGES=2 instance ----------------
  logic       v4, rdy4, ov4, ordy4, om4, oe4, m4;
  logic [3:0] d4, od4;
  logic       in_x4, out_x4, s_oe4;
  logic [3:0] s_od4;

  gray_code_pipe #(.N(4), .STAGES(2), .CHECK_EN(1)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .in_data(d4), .in_mode(m4),
    .out_valid(ov4), .out_ready(ordy4), .out_data(od4), .out_mode(om4), .out_step_err(oe4)
  );

  // ---------------- N=8 sweep instances ----------------
  logic       iv8 [3];
  logic       ir8 [3];
  logic [7:0] id8 [3];
  logic       im8 [3];
  logic       ov8 [3];
  logic       or8 [3];
  logic [7:0] od8 [3];
  logic       om8 [3];
  logic       oe8 [3];

  for (genvar k = 0; k < 3; k++) begin : g_sw
    gray_code_pipe #(.N(8), .STAGES(k == 0 ? 1 : (k == 1 ? 3 : 7)), .CHECK_EN(1)) u_dut (
      .clk(clk), .rst(rst), .in_valid(iv8[k]), .in_ready(ir8[k]), .in_data(id8[k]),
      .in_mode(im8[k]), .out_valid(ov8[k]), .out_ready(or8[k]), .out_data(od8[k]),
      .out_mode(om8[k]), .out_step_err(oe8[k])
    );
  end

  function automatic int st_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 7);
  endfunction

  typedef struct packed {
    logic [7:0]  d;
    logic        m;
    logic        e;
    int unsigned t;
  } exp_t;

  exp_t        ring8 [3][64];
  int unsigned wr8 [3];
  int unsigned rd8 [3];
  logic [7:0]  prev8 [3];
  logic        hp8 [3];
  logic        acc8 [3];
  int unsigned cyc = 0;

  // Drive at posedge+1, sample handshakes at posedge+2 (before the next edge).
  task automatic cycle4();
    #1;
    in_x4  = v4 && rdy4;
    out_x4 = ov4 && ordy4;
    s_od4  = od4;
    s_oe4  = oe4;
    @(posedge clk);
    #1;
  endtask

  task automatic cycle8(input bit lat_exact);
    exp_t e;
    logic [7:0] g;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (ov8[k] && or8[k]) begin
        check_eq($sformatf("sw%0d_has_exp", k), 32'(wr8[k] != rd8[k]), 32'(1));
        if (wr8[k] != rd8[k]) begin
          e = ring8[k][rd8[k] % 64];
          rd8[k]++;
          check_eq($sformatf("sw%0d_data", k), 32'(od8[k]), 32'(e.d));
          check_eq($sformatf("sw%0d_mode", k), 32'(om8[k]), 32'(e.m));
          check_eq($sformatf("sw%0d_err", k), 32'(oe8[k]), 32'(e.e));
          if (lat_exact)
            check_eq($sformatf("sw%0d_lat", k), cyc - e.t, 32'(st_of(k)));
          else
            check_eq($sformatf("sw%0d_latmin", k), 32'((cyc - e.t) >= 32'(st_of(k))), 32'(1));
        end
      end
      acc8[k] = iv8[k] && ir8[k];
      if (acc8[k]) begin
        g   = im8[k] ? m_b2g(id8[k]) : id8[k];
        e.d = im8[k] ? m_b2g(id8[k]) : m_g2b(id8[k]);
        e.m = im8[k];
        e.e = hp8[k] && ($countones(g ^ prev8[k]) != 1);
        e.t = cyc;
        ring8[k][wr8[k] % 64] = e;
        wr8[k]++;
        prev8[k] = g;
        hp8[k]   = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    v4 = 1'b0; ordy4 = 1'b1;
    cycle4();
    cycle4();
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] bin_q [$];
    logic [3:0] gray_q [$];
    logic [3:0] beats [4];
    logic [3:0] g3 [6];
    logic       e3 [6];
    int         idx, n_out;

    v4 = 1'b0; d4 = '0; m4 = 1'b0; ordy4 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iv8[k] = 1'b0; id8[k] = '0; im8[k] = 1'b0; or8[k] = 1'b1;
    end

    // Reset state and single G2B beat latency.
    do_reset();
    #1;
    check_eq("rst_out_valid", 32'(ov4), 32'(0));
    check_eq("rst_out_data", 32'(od4), 32'(0));
    check_eq("rst_out_mode", 32'(om4), 32'(0));
    check_eq("rst_step_err", 32'(oe4), 32'(0));
    check_eq("rst_in_ready", 32'(rdy4), 32'(1));
    v4 = 1'b1; d4 = 4'b0110; m4 = 1'b0;
    cycle4();
    check_eq("t1_accept", 32'(in_x4), 32'(1));
    v4 = 1'b0;
    #1;
    check_eq("t1_not_early", 32'(ov4), 32'(0));
    cycle4();
    check_eq("t1_valid", 32'(ov4), 32'(1));
    check_eq("t1_data", 32'(od4), 32'(4'b0100));
    check_eq("t1_mode", 32'(om4), 32'(0));
    check_eq("t1_err", 32'(oe4), 32'(0));

    // B2G 1011 -> 1110; 1110 ^ 0110 is one bit.
    v4 = 1'b1; d4 = 4'b1011; m4 = 1'b1;
    cycle4();
    v4 = 1'b0;
    cycle4();
    check_eq("t2_b2g_data", 32'(od4), 32'(4'b1110));
    check_eq("t2_b2g_mode", 32'(om4), 32'(1));
    check_eq("t2_b2g_err", 32'(oe4), 32'(0));
    cycle4();

    // Exhaustive round trip at 1 beat/clk.
    for (int c = 0; c < 18; c++) begin
      if (c < 16) begin v4 = 1'b1; d4 = 4'(c); m4 = 1'b1; end
      else v4 = 1'b0;
      cycle4();
      if (c < 16) check_eq("t2_fwd_accept", 32'(in_x4), 32'(1));
      if (out_x4) gray_q.push_back(s_od4);
    end
    check_eq("t2_fwd_count", 32'(gray_q.size()), 32'(16));
    for (int c = 0; c < 18; c++) begin
      if (c < 16 && c < gray_q.size()) begin
        v4 = 1'b1; d4 = gray_q[c]; m4 = 1'b0;
        check_eq("t2_gray_val", 32'(gray_q[c]), 32'(m_b2g(8'(c))));
      end else v4 = 1'b0;
      cycle4();
      if (c < 16) check_eq("t2_back_accept", 32'(in_x4), 32'(1));
      if (out_x4) bin_q.push_back(s_od4);
    end
    check_eq("t2_back_count", 32'(bin_q.size()), 32'(16));
    foreach (bin_q[i]) check_eq("t2_roundtrip", 32'(bin_q[i]), 32'(i));

    // Gray-step stream.
    do_reset();
    g3 = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0111, 4'b0111};
    e3 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    n_out = 0;
    for (int c = 0; c < 10; c++) begin
      if (c < 6) begin v4 = 1'b1; d4 = g3[c]; m4 = 1'b0; end
      else v4 = 1'b0;
      cycle4();
      if (out_x4 && n_out < 6) begin
        check_eq($sformatf("t3_err%0d", n_out), 32'(s_oe4), 32'(e3[n_out]));
        check_eq($sformatf("t3_data%0d", n_out), 32'(s_od4), 32'(m_g2b(8'(g3[n_out]))));
        n_out++;
      end
    end
    check_eq("t3_count", 32'(n_out), 32'(6));

    // Backpressure: 4 beats offered, out_ready held low.
    do_reset();
    beats = '{4'h3, 4'h9, 4'hC, 4'h5};
    idx = 0;
    ordy4 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      v4 = 1'b1; d4 = beats[idx]; m4 = 1'b0;
      cycle4();
      if (in_x4 && idx < 3) idx++;
    end
    check_eq("t4_accepted", 32'(idx), 32'(2));
    #1;
    check_eq("t4_in_ready", 32'(rdy4), 32'(0));
    for (int c = 0; c < 2; c++) begin
      check_eq("t4_hold_valid", 32'(ov4), 32'(1));
      check_eq("t4_hold_data", 32'(od4), 32'(m_g2b(8'(beats[0]))));
      cycle4();
    end
    ordy4 = 1'b1;
    n_out = 0;
    for (int c = 0; c < 20; c++) begin
      if (idx < 4) begin v4 = 1'b1; d4 = beats[idx]; end
      else v4 = 1'b0;
      cycle4();
      if (in_x4) idx++;
      if (out_x4) begin
        if (n_out < 4)
          check_eq($sformatf("t4_order%0d", n_out), 32'(s_od4), 32'(m_g2b(8'(beats[n_out]))));
        n_out++;
      end
    end
    check_eq("t4_out_count", 32'(n_out), 32'(4));

    // Reset with beats in flight.
    do_reset();
    ordy4 = 1'b0;
    v4 = 1'b1; d4 = 4'h0; m4 = 1'b0;
    cycle4();
    cycle4();
    v4 = 1'b0;
    rst = 1'b1;
    cycle4();
    rst = 1'b0;
    #1;
    check_eq("t5_flush_valid", 32'(ov4), 32'(0));
    ordy4 = 1'b1;
    n_out = 0;
    for (int c = 0; c < 5; c++) begin
      cycle4();
      if (out_x4) n_out++;
    end
    check_eq("t5_no_ghosts", 32'(n_out), 32'(0));
    v4 = 1'b1; d4 = 4'hF; m4 = 1'b0;
    cycle4();
    v4 = 1'b0;
    n_out = 0;
    for (int c = 0; c < 6 && n_out == 0; c++) begin
      cycle4();
      if (out_x4) begin
        n_out++;
        check_eq("t5_first_err", 32'(s_oe4), 32'(0));
        check_eq("t5_first_data", 32'(s_od4), 32'(4'hA));
      end
    end
    check_eq("t5_first_seen", 32'(n_out), 32'(1));

    // N=8 sweep: unstalled phase (exact latency) then random backpressure.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      wr8[k] = 0; rd8[k] = 0; prev8[k] = '0; hp8[k] = 1'b0; acc8[k] = 1'b0;
    end
    for (int c = 0; c < 900; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (!(iv8[k] && !acc8[k])) begin
          iv8[k] = ($urandom_range(0, 3) != 0);
          id8[k] = 8'($urandom);
          im8[k] = 1'($urandom);
        end
        or8[k] = (c < 300) ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
      cycle8(c < 300);
    end
    for (int k = 0; k < 3; k++) begin
      iv8[k] = 1'b0; or8[k] = 1'b1;
    end
    for (int c = 0; c < 20; c++) cycle8(1'b0);
    for (int k = 0; k < 3; k++)
      check_eq($sformatf("sw%0d_drained", k), wr8[k] - rd8[k], 32'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
